execute_stage: RTL and testbench

- EX stage of the 5-stage RISC-V pipeline: ID/EX register, forwarding muxes, ALU, branch resolution and EX/MEM register in one block.
- Consumes the 3-bit ALUControl produced by the ALU decoder in Decode, plus decoded operands and control.
- Drives the Memory stage, returns branch/jump redirects to Fetch and exposes hazard-unit taps.

---
 rtl/riscv_pkg.sv | 21 ++
 rtl/alu.sv | 34 +++
 rtl/execute_stage.sv | 166 ++++++++++++++++
 tb/tb_execute_stage.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared RISC-V pipeline definitions: datapath width, ALU operation codes and
// forwarding-select encodings used by the execute stage.
package riscv_pkg;

    localparam int XLEN = 32;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_SLT = 3'b101
    } alu_op_e;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_sel_e;

endpackage

// File: rtl/alu.sv
// Combinational integer ALU for the execute stage: add, sub, and, or and
// signed set-less-than; unassigned operation codes yield zero.
module alu
    import riscv_pkg::*;
#(
    parameter int XLEN = riscv_pkg::XLEN
) (
    input  logic [XLEN-1:0] SrcA,
    input  logic [XLEN-1:0] SrcB,
    input  logic [2:0]      ALUControl,
    output logic [XLEN-1:0] Result,
    output logic            Zero
);

    logic slt_bit;

    assign slt_bit = ($signed(SrcA) < $signed(SrcB));

    always_comb begin
        // NOTE: default first so every path assigns Result and no latch is inferred.
        Result = '0;
        case (ALUControl)
            ALU_ADD: Result = SrcA + SrcB;
            ALU_SUB: Result = SrcA - SrcB;
            ALU_AND: Result = SrcA & SrcB;
            ALU_OR:  Result = SrcA | SrcB;
            ALU_SLT: Result = {{(XLEN-1){1'b0}}, slt_bit};
            default: Result = '0;
        endcase
    end

    assign Zero = (Result == '0);

endmodule

// File: rtl/execute_stage.sv
// EX stage of the 5-stage pipeline: ID/EX register, operand forwarding, ALU,
// branch resolution and the EX/MEM register feeding the Memory stage.
module execute_stage
    import riscv_pkg::*;
#(
    parameter int XLEN   = riscv_pkg::XLEN,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              StallE,
    input  logic              FlushE,
    input  logic              RegWriteD,
    input  logic              MemWriteD,
    input  logic              JumpD,
    input  logic              BranchD,
    input  logic              ALUSrcD,
    input  logic [1:0]        ResultSrcD,
    input  logic [2:0]        ALUControlD,
    input  logic [XLEN-1:0]   RD1D,
    input  logic [XLEN-1:0]   RD2D,
    input  logic [XLEN-1:0]   PCD,
    input  logic [XLEN-1:0]   ImmExtD,
    input  logic [XLEN-1:0]   PCPlus4D,
    input  logic [REG_AW-1:0] Rs1D,
    input  logic [REG_AW-1:0] Rs2D,
    input  logic [REG_AW-1:0] RdD,
    input  logic [1:0]        ForwardAE,
    input  logic [1:0]        ForwardBE,
    input  logic [XLEN-1:0]   ResultW,
    output logic              PCSrcE,
    output logic [XLEN-1:0]   PCTargetE,
    output logic [REG_AW-1:0] Rs1E,
    output logic [REG_AW-1:0] Rs2E,
    output logic [REG_AW-1:0] RdE,
    output logic              ResultSrcE0,
    output logic              RegWriteM,
    output logic              MemWriteM,
    output logic [1:0]        ResultSrcM,
    output logic [XLEN-1:0]   ALUResultM,
    output logic [XLEN-1:0]   WriteDataM,
    output logic [XLEN-1:0]   PCPlus4M,
    output logic [REG_AW-1:0] RdM
);

    typedef struct packed {
        logic              reg_write;
        logic              mem_write;
        logic              jump;
        logic              branch;
        logic              alu_src;
        logic [1:0]        result_src;
        logic [2:0]        alu_control;
        logic [XLEN-1:0]   rd1;
        logic [XLEN-1:0]   rd2;
        logic [XLEN-1:0]   pc;
        logic [XLEN-1:0]   imm_ext;
        logic [XLEN-1:0]   pc_plus4;
        logic [REG_AW-1:0] rs1;
        logic [REG_AW-1:0] rs2;
        logic [REG_AW-1:0] rd;
    } id_ex_t;

    typedef struct packed {
        logic              reg_write;
        logic              mem_write;
        logic [1:0]        result_src;
        logic [XLEN-1:0]   alu_result;
        logic [XLEN-1:0]   write_data;
        logic [REG_AW-1:0] rd;
        logic [XLEN-1:0]   pc_plus4;
    } ex_mem_t;

    id_ex_t          id_ex_d, id_ex_q;
    ex_mem_t         ex_mem_d, ex_mem_q;
    logic [XLEN-1:0] src_a_e, src_b_e, write_data_e, alu_result_e;
    logic            zero_e;

    // A flush forces a bubble even while the stage is stalled.
    always_comb begin
        id_ex_d = id_ex_q;
        if (FlushE) begin
            id_ex_d = '0;
        end else if (!StallE) begin
            id_ex_d = '{
                reg_write:   RegWriteD,
                mem_write:   MemWriteD,
                jump:        JumpD,
                branch:      BranchD,
                alu_src:     ALUSrcD,
                result_src:  ResultSrcD,
                alu_control: ALUControlD,
                rd1:         RD1D,
                rd2:         RD2D,
                pc:          PCD,
                imm_ext:     ImmExtD,
                pc_plus4:    PCPlus4D,
                rs1:         Rs1D,
                rs2:         Rs2D,
                rd:          RdD
            };
        end
    end

    always_comb begin
        case (ForwardAE)
            FWD_RF:  src_a_e = id_ex_q.rd1;
            FWD_WB:  src_a_e = ResultW;
            FWD_MEM: src_a_e = ex_mem_q.alu_result;
            default: src_a_e = id_ex_q.rd1;
        endcase
        case (ForwardBE)
            FWD_RF:  write_data_e = id_ex_q.rd2;
            FWD_WB:  write_data_e = ResultW;
            FWD_MEM: write_data_e = ex_mem_q.alu_result;
            default: write_data_e = id_ex_q.rd2;
        endcase
    end

    assign src_b_e = id_ex_q.alu_src ? id_ex_q.imm_ext : write_data_e;

    alu #(.XLEN(XLEN)) u_alu (
        .SrcA       (src_a_e),
        .SrcB       (src_b_e),
        .ALUControl (id_ex_q.alu_control),
        .Result     (alu_result_e),
        .Zero       (zero_e)
    );

    assign ex_mem_d = '{
        reg_write:  id_ex_q.reg_write,
        mem_write:  id_ex_q.mem_write,
        result_src: id_ex_q.result_src,
        alu_result: alu_result_e,
        write_data: write_data_e,
        rd:         id_ex_q.rd,
        pc_plus4:   id_ex_q.pc_plus4
    };

    always_ff @(posedge clk) begin
        // NOTE: non-blocking updates so both pipeline registers sample pre-edge values.
        if (rst) begin
            id_ex_q  <= '0;
            ex_mem_q <= '0;
        end else begin
            id_ex_q  <= id_ex_d;
            ex_mem_q <= ex_mem_d;
        end
    end

    assign PCSrcE      = id_ex_q.jump | (id_ex_q.branch & zero_e);
    assign PCTargetE   = id_ex_q.pc + id_ex_q.imm_ext;
    assign Rs1E        = id_ex_q.rs1;
    assign Rs2E        = id_ex_q.rs2;
    assign RdE         = id_ex_q.rd;
    assign ResultSrcE0 = id_ex_q.result_src[0];

    assign RegWriteM  = ex_mem_q.reg_write;
    assign MemWriteM  = ex_mem_q.mem_write;
    assign ResultSrcM = ex_mem_q.result_src;
    assign ALUResultM = ex_mem_q.alu_result;
    assign WriteDataM = ex_mem_q.write_data;
    assign PCPlus4M   = ex_mem_q.pc_plus4;
    assign RdM        = ex_mem_q.rd;

endmodule

// File: tb/tb_execute_stage.sv
// Self-checking bench for execute_stage: a reference model pushes the expected
// EX/MEM contents when each instruction executes and pops them one edge later.
module tb_execute_stage;

    localparam int XLEN   = 32;
    localparam int REG_AW = 5;

    typedef struct packed {
        logic              reg_write;
        logic              mem_write;
        logic              jump;
        logic              branch;
        logic              alu_src;
        logic [1:0]        result_src;
        logic [2:0]        alu_ctl;
        logic [XLEN-1:0]   rd1;
        logic [XLEN-1:0]   rd2;
        logic [XLEN-1:0]   pc;
        logic [XLEN-1:0]   imm;
        logic [XLEN-1:0]   pc4;
        logic [REG_AW-1:0] rs1;
        logic [REG_AW-1:0] rs2;
        logic [REG_AW-1:0] rd;
    } instr_t;

    typedef struct packed {
        logic              reg_write;
        logic              mem_write;
        logic [1:0]        result_src;
        logic [XLEN-1:0]   alu_result;
        logic [XLEN-1:0]   write_data;
        logic [REG_AW-1:0] rd;
        logic [XLEN-1:0]   pc4;
    } exp_m_t;

    logic clk = 1'b0, rst = 1'b1, StallE = 1'b0, FlushE = 1'b0;
    logic RegWriteD = 1'b0, MemWriteD = 1'b0, JumpD = 1'b0, BranchD = 1'b0, ALUSrcD = 1'b0;
    logic [1:0]        ResultSrcD = '0, ForwardAE = '0, ForwardBE = '0;
    logic [2:0]        ALUControlD = '0;
    logic [XLEN-1:0]   RD1D = '0, RD2D = '0, PCD = '0, ImmExtD = '0, PCPlus4D = '0, ResultW = '0;
    logic [REG_AW-1:0] Rs1D = '0, Rs2D = '0, RdD = '0;
    logic              PCSrcE, ResultSrcE0, RegWriteM, MemWriteM;
    logic [XLEN-1:0]   PCTargetE, ALUResultM, WriteDataM, PCPlus4M;
    logic [REG_AW-1:0] Rs1E, Rs2E, RdE, RdM;
    logic [1:0]        ResultSrcM;

    execute_stage #(.XLEN(XLEN), .REG_AW(REG_AW)) dut (
        .clk(clk), .rst(rst), .StallE(StallE), .FlushE(FlushE),
        .RegWriteD(RegWriteD), .MemWriteD(MemWriteD), .JumpD(JumpD), .BranchD(BranchD),
        .ALUSrcD(ALUSrcD), .ResultSrcD(ResultSrcD), .ALUControlD(ALUControlD),
        .RD1D(RD1D), .RD2D(RD2D), .PCD(PCD), .ImmExtD(ImmExtD), .PCPlus4D(PCPlus4D),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD), .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .ResultW(ResultW), .PCSrcE(PCSrcE), .PCTargetE(PCTargetE), .Rs1E(Rs1E), .Rs2E(Rs2E),
        .RdE(RdE), .ResultSrcE0(ResultSrcE0), .RegWriteM(RegWriteM), .MemWriteM(MemWriteM),
        .ResultSrcM(ResultSrcM), .ALUResultM(ALUResultM), .WriteDataM(WriteDataM),
        .PCPlus4M(PCPlus4M), .RdM(RdM)
    );

    always #5 clk = ~clk;

    int        n_vec = 0;
    int        n_bad = 0;
    exp_m_t    exp_q[$];
    instr_t    e_model;
    logic [XLEN-1:0] m_alu_model;

    function automatic logic [XLEN-1:0] alu_model(input logic [2:0] ctl,
                                                  input logic [XLEN-1:0] a, b);
        case (ctl)
            3'd0:    return a + b;
            3'd1:    return a - b;
            3'd2:    return a & b;
            3'd3:    return a | b;
            3'd5:    return ($signed(a) < $signed(b)) ? 1 : 0;
            default: return '0;
        endcase
    endfunction

    function automatic logic [XLEN-1:0] fwd_model(input logic [1:0] sel,
                                                  input logic [XLEN-1:0] rf, wb, mem);
        if (sel == 2'b01) return wb;
        if (sel == 2'b10) return mem;
        return rf;
    endfunction

    // One clock of stimulus: forwarding inputs for the instruction now in E,
    // decode inputs for the next capture, then retire the E instruction into M.
    task automatic step(input instr_t d, input logic [1:0] fa, fb,
                        input logic [XLEN-1:0] rw, input logic stall, flush);
        logic [XLEN-1:0] sa, wd, sb, res, tgt;
        logic            pcsrc;
        exp_m_t          exp, got;
        ForwardAE = fa; ForwardBE = fb; ResultW = rw; StallE = stall; FlushE = flush;
        RegWriteD = d.reg_write; MemWriteD = d.mem_write; JumpD = d.jump; BranchD = d.branch;
        ALUSrcD = d.alu_src; ResultSrcD = d.result_src; ALUControlD = d.alu_ctl;
        RD1D = d.rd1; RD2D = d.rd2; PCD = d.pc; ImmExtD = d.imm; PCPlus4D = d.pc4;
        Rs1D = d.rs1; Rs2D = d.rs2; RdD = d.rd;
        #1;
        sa    = fwd_model(fa, e_model.rd1, rw, m_alu_model);
        wd    = fwd_model(fb, e_model.rd2, rw, m_alu_model);
        sb    = e_model.alu_src ? e_model.imm : wd;
        res   = alu_model(e_model.alu_ctl, sa, sb);
        pcsrc = e_model.jump | (e_model.branch & (res == '0));
        tgt   = e_model.pc + e_model.imm;
        n_vec++;
        if ({PCSrcE, PCTargetE} !== {pcsrc, tgt}) begin
            n_bad++;
            $display("FAIL redirect_e: got pcsrc=%b target=%h, expected pcsrc=%b target=%h",
                     PCSrcE, PCTargetE, pcsrc, tgt);
        end
        n_vec++;
        if ({Rs1E, Rs2E, RdE, ResultSrcE0} !==
            {e_model.rs1, e_model.rs2, e_model.rd, e_model.result_src[0]}) begin
            n_bad++;
            $display("FAIL hazard_taps: got %h, expected %h", {Rs1E, Rs2E, RdE, ResultSrcE0},
                     {e_model.rs1, e_model.rs2, e_model.rd, e_model.result_src[0]});
        end
        exp_q.push_back('{e_model.reg_write, e_model.mem_write, e_model.result_src,
                          res, wd, e_model.rd, e_model.pc4});
        @(posedge clk);
        #1;
        ForwardAE = 2'b00; ForwardBE = 2'b00;
        got = '{RegWriteM, MemWriteM, ResultSrcM, ALUResultM, WriteDataM, RdM, PCPlus4M};
        n_vec++;
        if (exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL scoreboard_empty: got an M result with no expectation queued");
        end else begin
            exp = exp_q.pop_front();
            if (got !== exp) begin
                n_bad++;
                $display("FAIL ex_mem: got %h, expected %h", got, exp);
            end
            m_alu_model = exp.alu_result;
        end
        if (flush) e_model = '0;
        else if (!stall) e_model = d;
    endtask

    task automatic check_all_zero(input string tag);
        n_vec++;
        if ({Rs1E, Rs2E, RdE, ResultSrcE0, PCSrcE, PCTargetE, RegWriteM, MemWriteM,
             ResultSrcM, ALUResultM, WriteDataM, PCPlus4M, RdM} !== '0) begin
            n_bad++;
            $display("FAIL %s: got E taps rd=%h pcsrc=%b target=%h, M rw=%b mw=%b alu=%h rd=%h, expected all 0",
                     tag, RdE, PCSrcE, PCTargetE, RegWriteM, MemWriteM, ALUResultM, RdM);
        end
        exp_q.delete();
        e_model     = '0;
        m_alu_model = '0;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check_all_zero("reset_state");
    endtask

    task automatic test_add();
        instr_t i = '0;
        i.rd1 = 5; i.rd2 = 7; i.rd = 3; i.reg_write = 1'b1; i.rs1 = 1; i.rs2 = 2; i.pc4 = 32'h44;
        step(i, 2'b00, 2'b00, '0, 1'b0, 1'b0);
        step('0, 2'b00, 2'b00, '0, 1'b0, 1'b0);
        n_vec++;
        if ({ALUResultM, RdM, RegWriteM} !== {32'd12, 5'd3, 1'b1}) begin
            n_bad++;
            $display("FAIL add: got alu=%h rd=%h rw=%b, expected alu=0000000c rd=03 rw=1",
                     ALUResultM, RdM, RegWriteM);
        end
    endtask

    task automatic test_slt();
        instr_t i = '0;
        i.alu_ctl = 3'b101; i.rd1 = 32'hFFFF_FFFF; i.rd2 = 1;
        step(i, 2'b00, 2'b00, '0, 1'b0, 1'b0);
        i.rd1 = 1; i.rd2 = 32'hFFFF_FFFF;
        step(i, 2'b00, 2'b00, '0, 1'b0, 1'b0);
        n_vec++;
        if (ALUResultM !== 32'd1) begin
            n_bad++;
            $display("FAIL slt_neg_lt_pos: got %h, expected 00000001", ALUResultM);
        end
        step('0, 2'b00, 2'b00, '0, 1'b0, 1'b0);
        n_vec++;
        if (ALUResultM !== 32'd0) begin
            n_bad++;
            $display("FAIL slt_pos_lt_neg: got %h, expected 00000000", ALUResultM);
        end
    endtask

    task automatic test_forwarding();
        instr_t op1 = '0, op2 = '0;
        op1.rd1 = 32'h10; op1.alu_src = 1'b1; op1.rd = 4; op1.reg_write = 1'b1;
        op2.rd1 = 0; op2.imm = 4; op2.alu_src = 1'b1; op2.rs1 = 4; op2.rd = 5;
        step(op1, 2'b00, 2'b00, '0, 1'b0, 1'b0);
        step(op2, 2'b00, 2'b00, '0, 1'b0, 1'b0);
        step(op2, 2'b10, 2'b00, '0, 1'b0, 1'b0);
        n_vec++;
        if (ALUResultM !== 32'h14) begin
            n_bad++;
            $display("FAIL fwd_mem: got %h, expected 00000014", ALUResultM);
        end
        step('0, 2'b01, 2'b00, 32'h20, 1'b0, 1'b0);
        n_vec++;
        if (ALUResultM !== 32'h24) begin
            n_bad++;
            $display("FAIL fwd_wb: got %h, expected 00000024", ALUResultM);
        end
    endtask

    task automatic test_branch();
        instr_t b = '0;
        b.branch = 1'b1; b.alu_ctl = 3'b001; b.rd1 = 9; b.rd2 = 9; b.pc = 32'h100; b.imm = 32'h20;
        step(b, 2'b00, 2'b00, '0, 1'b0, 1'b0);
        n_vec++;
        if ({PCSrcE, PCTargetE} !== {1'b1, 32'h120}) begin
            n_bad++;
            $display("FAIL branch_taken: got pcsrc=%b target=%h, expected pcsrc=1 target=00000120",
                     PCSrcE, PCTargetE);
        end
        b.rd2 = 8;
        step(b, 2'b00, 2'b00, '0, 1'b0, 1'b0);
        n_vec++;
        if (PCSrcE !== 1'b0) begin
            n_bad++;
            $display("FAIL branch_not_taken: got pcsrc=%b, expected 0", PCSrcE);
        end
        step('0, 2'b00, 2'b00, '0, 1'b0, 1'b0);
    endtask

    task automatic test_stall_flush();
        instr_t x = '0, y = '0;
        x.rd1 = 1; x.rd2 = 2; x.rd = 7; x.reg_write = 1'b1; x.mem_write = 1'b1; x.jump = 1'b1;
        y.rd1 = 40; y.rd2 = 2; y.rd = 9; y.reg_write = 1'b1;
        step(x, 2'b00, 2'b00, '0, 1'b0, 1'b0);
        for (int k = 0; k < 2; k++) begin
            step(y, 2'b00, 2'b00, '0, 1'b1, 1'b0);
            n_vec++;
            if ({RdE, ALUResultM} !== {5'd7, 32'd3}) begin
                n_bad++;
                $display("FAIL stall_hold: got rd_e=%h alu_m=%h, expected rd_e=07 alu_m=00000003",
                         RdE, ALUResultM);
            end
        end
        step(y, 2'b00, 2'b00, '0, 1'b1, 1'b1);
        n_vec++;
        if ({RdE, PCSrcE} !== {5'd0, 1'b0}) begin
            n_bad++;
            $display("FAIL flush_bubble: got rd_e=%h pcsrc=%b, expected rd_e=00 pcsrc=0", RdE, PCSrcE);
        end
        step('0, 2'b00, 2'b00, '0, 1'b0, 1'b0);
        n_vec++;
        if ({RegWriteM, MemWriteM} !== 2'b00) begin
            n_bad++;
            $display("FAIL flush_m: got rw=%b mw=%b, expected rw=0 mw=0", RegWriteM, MemWriteM);
        end
    endtask

    task automatic test_alu_ops();
        instr_t i;
        for (int k = 0; k < 8; k++) begin
            i = '0;
            i.alu_ctl = 3'(k); i.rd1 = $urandom; i.rd2 = $urandom;
            i.rs1 = 5'(k + 1); i.rs2 = 5'(k + 9); i.rd = 5'(k + 17);
            i.result_src = 2'(k); i.pc = $urandom; i.imm = $urandom; i.pc4 = $urandom;
            i.mem_write = k[0]; i.reg_write = k[1]; i.jump = (k == 4);
            if (k == 0) begin i.rd1 = 32'hFFFF_FFFF; i.rd2 = 2; end
            step(i, 2'(k % 3), 2'((k + 1) % 3), $urandom, 1'b0, 1'b0);
        end
        step('0, 2'b00, 2'b01, 32'hA5A5_0001, 1'b0, 1'b0);
    endtask

    task automatic test_back_to_back();
        instr_t i = '0;
        for (int k = 0; k < 6; k++) begin
            i.alu_ctl = 3'b000; i.rd1 = $urandom; i.rd2 = 32'(k); i.rd = 5'(k + 1);
            i.reg_write = 1'b1; i.pc4 = 32'(4 * k);
            step(i, (k > 0) ? 2'b10 : 2'b00, 2'b00, '0, 1'b0, 1'b0);
        end
        step('0, 2'b10, 2'b10, '0, 1'b0, 1'b0);
    endtask

    task automatic test_reset_mid();
        instr_t i = '0;
        i.rd1 = 3; i.rd2 = 4; i.rd = 11; i.reg_write = 1'b1; i.mem_write = 1'b1;
        i.jump = 1'b1; i.pc = 32'h200; i.imm = 8; i.pc4 = 32'h204; i.rs1 = 2; i.rs2 = 6;
        step(i, 2'b00, 2'b00, '0, 1'b0, 1'b0);
        step(i, 2'b00, 2'b00, '0, 1'b0, 1'b0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_all_zero("reset_midstream");
        step('0, 2'b00, 2'b00, '0, 1'b0, 1'b0);
    endtask

    initial begin
        e_model     = '0;
        m_alu_model = '0;
        test_reset();
        test_add();
        test_slt();
        test_forwarding();
        test_branch();
        test_stall_flush();
        test_alu_ops();
        test_back_to_back();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
